// File: rtl/evt_counter_pkg.sv
// Shared types and defaults for the multi-channel event counter and its readout consumers.
package evt_counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } count_mode_e;

    typedef enum logic {
        TRIG_LEVEL = 1'b0,
        TRIG_EDGE  = 1'b1
    } trig_mode_e;

    localparam int unsigned DEF_NUM_CH    = 4;
    localparam int unsigned DEF_WIDTH     = 27;
    localparam int unsigned DEF_MAX_COUNT = 100_000_000;

    // True when a counter of w bits can hold every value 0..max_count-1.
    function automatic bit width_fits(input int unsigned w, input longint unsigned max_count);
        if (w >= 64) begin
            return 1'b1;
        end
        return ((64'd1 << w) >= max_count);
    endfunction

    function automatic count_mode_e to_count_mode(input int unsigned saturate);
        return (saturate != 0) ? CNT_SAT : CNT_WRAP;
    endfunction

    function automatic trig_mode_e to_trig_mode(input int unsigned edge_mode);
        return (edge_mode != 0) ? TRIG_EDGE : TRIG_LEVEL;
    endfunction

endpackage

// File: rtl/evt_counter_ch.sv
// One counter channel: optional rising-edge qualification, modulo/saturating count,
// terminal-count pulse and sticky overflow.
module evt_counter_ch
    import evt_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_COUNT = DEF_MAX_COUNT,
    parameter count_mode_e CNT_MODE  = CNT_WRAP,
    parameter trig_mode_e  TRIG_MODE = TRIG_LEVEL
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_in,
    input  logic             evt_in,
    input  logic             clr_in,
    output logic [WIDTH-1:0] count_out,
    output logic             tc_out,
    output logic             ovf_out
);

    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(MAX_COUNT - 1);

    logic             r_evt_d;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_qual;
    logic             w_inc;
    logic             w_at_last;
    logic [WIDTH-1:0] w_count_p1;

    always_comb begin
        w_qual = (TRIG_MODE == TRIG_EDGE) ? (evt_in & ~r_evt_d) : evt_in;
    end

    assign w_inc      = en_in & w_qual;
    assign w_at_last  = (r_count == LP_LAST);
    assign w_count_p1 = r_count + WIDTH'(1);

    // Edge history tracks evt_in every cycle so edges seen while disabled or cleared are consumed.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_evt_d <= 1'b0;
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_evt_d <= evt_in;
            r_tc    <= 1'b0;
            if (clr_in) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_inc) begin
                if (w_at_last) begin
                    r_ovf <= 1'b1;
                    if (CNT_MODE == CNT_WRAP) begin
                        r_count <= '0;
                        r_tc    <= 1'b1;
                    end
                end else begin
                    r_count <= w_count_p1;
                    if ((CNT_MODE == CNT_SAT) && (w_count_p1 == LP_LAST)) begin
                        r_tc <= 1'b1;
                    end
                end
            end
        end
    end

    assign count_out = r_count;
    assign tc_out    = r_tc;
    assign ovf_out   = r_ovf;

endmodule

// File: rtl/multi_evt_counter.sv
// N-channel event counter with global enable and coherent all-channel snapshot;
// per-channel counting lives in evt_counter_ch.
module multi_evt_counter
    import evt_counter_pkg::*;
#(
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_COUNT = DEF_MAX_COUNT,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned EDGE_MODE = 0
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         en_in,
    input  logic [NUM_CH-1:0]            evt_in,
    input  logic [NUM_CH-1:0]            clr_in,
    input  logic                         snap_in,
    output logic [NUM_CH-1:0][WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0][WIDTH-1:0] snap_out,
    output logic                         snap_valid_out,
    output logic [NUM_CH-1:0]            tc_out,
    output logic [NUM_CH-1:0]            ovf_out
);

    localparam count_mode_e LP_CNT_MODE  = to_count_mode(SATURATE);
    localparam trig_mode_e  LP_TRIG_MODE = to_trig_mode(EDGE_MODE);

    if (!width_fits(WIDTH, longint'(MAX_COUNT))) begin : g_bad_width
        $error("multi_evt_counter: WIDTH too small to hold MAX_COUNT-1");
    end
    if (MAX_COUNT < 2) begin : g_bad_max
        $error("multi_evt_counter: MAX_COUNT must be at least 2");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $error("multi_evt_counter: NUM_CH must be at least 1");
    end

    logic [NUM_CH-1:0][WIDTH-1:0] w_count;
    logic [NUM_CH-1:0]            w_tc;
    logic [NUM_CH-1:0]            w_ovf;

    logic [NUM_CH-1:0][WIDTH-1:0] r_snap;
    logic                         r_snap_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        evt_counter_ch #(
            .WIDTH     (WIDTH),
            .MAX_COUNT (MAX_COUNT),
            .CNT_MODE  (LP_CNT_MODE),
            .TRIG_MODE (LP_TRIG_MODE)
        ) u_ch (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .en_in     (en_in),
            .evt_in    (evt_in[g]),
            .clr_in    (clr_in[g]),
            .count_out (w_count[g]),
            .tc_out    (w_tc[g]),
            .ovf_out   (w_ovf[g])
        );
    end

    // Capture from the registered counts, so the snapshot holds pre-increment/pre-clear values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= snap_in;
            if (snap_in) begin
                r_snap <= w_count;
            end
        end
    end

    assign count_out      = w_count;
    assign snap_out       = r_snap;
    assign snap_valid_out = r_snap_valid;
    assign tc_out         = w_tc;
    assign ovf_out        = w_ovf;

endmodule

// File: tb/tb_multi_evt_counter.sv
// Bench for multi_evt_counter: wrap, saturate and edge-mode instances share stimulus and
// are compared against an arithmetic reference model.
module tb_multi_evt_counter;

    localparam int NCH  = 4;
    localparam int W    = 4;
    localparam int MAXC = 10;
    localparam int NI   = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [NCH-1:0] evt = '0;
    logic [NCH-1:0] clr = '0;
    logic           snap = 1'b0;

    logic [NCH-1:0][W-1:0] cnt_w, cnt_s, cnt_e, snp_w, snp_s, snp_e;
    logic                  sv_w, sv_s, sv_e;
    logic [NCH-1:0]        tc_w, tc_s, tc_e, ovf_w, ovf_s, ovf_e;

    int checks = 0;
    int errors = 0;

    int m_cnt  [NI][NCH];
    int m_snap [NI][NCH];
    bit m_tc   [NI][NCH];
    bit m_ovf  [NI][NCH];
    bit m_prev [NI][NCH];
    bit m_snapv[NI];
    bit is_sat [NI] = '{0, 1, 0};
    bit is_edge[NI] = '{0, 0, 1};

    always #5 clk = ~clk;

    multi_evt_counter #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(MAXC), .SATURATE(0), .EDGE_MODE(0)) dut_w (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .evt_in(evt), .clr_in(clr), .snap_in(snap),
        .count_out(cnt_w), .snap_out(snp_w), .snap_valid_out(sv_w), .tc_out(tc_w), .ovf_out(ovf_w));

    multi_evt_counter #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(MAXC), .SATURATE(1), .EDGE_MODE(0)) dut_s (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .evt_in(evt), .clr_in(clr), .snap_in(snap),
        .count_out(cnt_s), .snap_out(snp_s), .snap_valid_out(sv_s), .tc_out(tc_s), .ovf_out(ovf_s));

    multi_evt_counter #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(MAXC), .SATURATE(0), .EDGE_MODE(1)) dut_e (
        .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .evt_in(evt), .clr_in(clr), .snap_in(snap),
        .count_out(cnt_e), .snap_out(snp_e), .snap_valid_out(sv_e), .tc_out(tc_e), .ovf_out(ovf_e));

    function automatic int get_cnt(input int k, input int c);
        case (k)
            0: return int'(cnt_w[c]);
            1: return int'(cnt_s[c]);
            default: return int'(cnt_e[c]);
        endcase
    endfunction

    function automatic int get_snp(input int k, input int c);
        case (k)
            0: return int'(snp_w[c]);
            1: return int'(snp_s[c]);
            default: return int'(snp_e[c]);
        endcase
    endfunction

    function automatic logic get_tc(input int k, input int c);
        case (k)
            0: return tc_w[c];
            1: return tc_s[c];
            default: return tc_e[c];
        endcase
    endfunction

    function automatic logic get_ovf(input int k, input int c);
        case (k)
            0: return ovf_w[c];
            1: return ovf_s[c];
            default: return ovf_e[c];
        endcase
    endfunction

    function automatic logic get_sv(input int k);
        case (k)
            0: return sv_w;
            1: return sv_s;
            default: return sv_e;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_snapv[k] = 0;
            for (int c = 0; c < NCH; c++) begin
                m_cnt[k][c] = 0; m_snap[k][c] = 0; m_tc[k][c] = 0;
                m_ovf[k][c] = 0; m_prev[k][c] = 0;
            end
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs as sampled at that edge.
    task automatic model_clock();
        bit q;
        for (int k = 0; k < NI; k++) begin
            m_snapv[k] = snap;
            for (int c = 0; c < NCH; c++) begin
                if (snap) m_snap[k][c] = m_cnt[k][c];
                q = is_edge[k] ? (evt[c] && !m_prev[k][c]) : evt[c];
                m_prev[k][c] = evt[c];
                m_tc[k][c] = 0;
                if (clr[c]) begin
                    m_cnt[k][c] = 0;
                    m_ovf[k][c] = 0;
                end else if (en && q) begin
                    if (!is_sat[k]) begin
                        m_cnt[k][c] = (m_cnt[k][c] + 1) % MAXC;
                        if (m_cnt[k][c] == 0) begin
                            m_tc[k][c]  = 1;
                            m_ovf[k][c] = 1;
                        end
                    end else if (m_cnt[k][c] == MAXC - 1) begin
                        m_ovf[k][c] = 1;
                    end else begin
                        m_cnt[k][c] = m_cnt[k][c] + 1;
                        m_tc[k][c]  = (m_cnt[k][c] == MAXC - 1);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_all();
        en = 0; evt = '0; snap = 0; clr = '1;
        step();
        clr = '0;
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (get_cnt(k, c) !== 0 || get_snp(k, c) !== 0 || get_tc(k, c) !== 1'b0 || get_ovf(k, c) !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_init k=%0d c=%0d cnt=%0d snp=%0d tc=%b ovf=%b required all 0",
                             k, c, get_cnt(k, c), get_snp(k, c), get_tc(k, c), get_ovf(k, c));
                end
            end
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        en = 1; evt = 4'b0001; snap = 1;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (cnt_w[0] !== W'(7)) begin
            errors++;
            $display("FAIL reset_precount got %0d required 7", cnt_w[0]);
        end
        #2;
        rst_n = 0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (get_sv(k) !== 1'b0) begin
                errors++;
                $display("FAIL reset_async_sv k=%0d got %b required 0", k, get_sv(k));
            end
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (get_cnt(k, c) !== 0 || get_snp(k, c) !== 0 || get_tc(k, c) !== 1'b0 || get_ovf(k, c) !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_async k=%0d c=%0d cnt=%0d snp=%0d tc=%b ovf=%b required all 0",
                             k, c, get_cnt(k, c), get_snp(k, c), get_tc(k, c), get_ovf(k, c));
                end
            end
        end
        model_reset();
        en = 0; evt = '0; snap = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_wrap();
        int exp;
        int tc_pulses = 0;
        clear_all();
        en = 1; evt = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            step();
            exp = (i + 1) % MAXC;
            if (tc_w[0]) tc_pulses++;
            checks++;
            if (cnt_w[0] !== W'(exp) || tc_w[0] !== (exp == 0)) begin
                errors++;
                $display("FAIL wrap_seq i=%0d cnt=%0d tc=%b required cnt=%0d tc=%b", i, cnt_w[0], tc_w[0], exp, exp == 0);
            end
        end
        checks++;
        if (tc_pulses != 1 || ovf_w[0] !== 1'b1 || cnt_w[3:1] !== '0 || ovf_w[3:1] !== '0) begin
            errors++;
            $display("FAIL wrap_final tc_pulses=%0d ovf=%b other_cnt=%h required 1 1 000", tc_pulses, ovf_w[0], cnt_w[3:1]);
        end
        evt = '0; en = 0;
    endtask

    task automatic test_saturate();
        int exp;
        clear_all();
        en = 1; evt = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            step();
            exp = (i + 1 < MAXC - 1) ? i + 1 : MAXC - 1;
            checks++;
            if (cnt_s[0] !== W'(exp) || tc_s[0] !== (i == MAXC - 2) || ovf_s[0] !== (i >= MAXC - 1)) begin
                errors++;
                $display("FAIL sat_seq i=%0d cnt=%0d tc=%b ovf=%b required cnt=%0d tc=%b ovf=%b",
                         i, cnt_s[0], tc_s[0], ovf_s[0], exp, i == MAXC - 2, i >= MAXC - 1);
            end
        end
        evt = '0; en = 0; clr = 4'b0001;
        step();
        clr = '0;
        checks++;
        if (cnt_s[0] !== '0 || ovf_s[0] !== 1'b0 || tc_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear cnt=%0d ovf=%b tc=%b required 0 0 0", cnt_s[0], ovf_s[0], tc_s[0]);
        end
    endtask

    task automatic test_edge();
        clear_all();
        step();
        en = 1; evt = 4'b0001;
        for (int i = 0; i < 8; i++) step();
        evt = '0;
        step();
        checks++;
        if (cnt_e[0] !== W'(1)) begin
            errors++;
            $display("FAIL edge_hold got %0d required 1", cnt_e[0]);
        end
        for (int i = 0; i < 8; i++) begin
            evt[0] = (i % 2 == 1);
            step();
        end
        checks++;
        if (cnt_e[0] !== W'(5)) begin
            errors++;
            $display("FAIL edge_toggle got %0d required 5", cnt_e[0]);
        end
        evt = '0; en = 0;
    endtask

    task automatic test_collision();
        clear_all();
        en = 1; evt = 4'b0001; clr = 4'b0001;
        step();
        clr = '0;
        checks++;
        if (cnt_w[0] !== '0 || cnt_s[0] !== '0) begin
            errors++;
            $display("FAIL clr_beats_evt got %0d/%0d required 0", cnt_w[0], cnt_s[0]);
        end
        for (int i = 0; i < 5; i++) step();
        snap = 1;
        step();
        snap = 0;
        checks++;
        if (snp_w[0] !== W'(5) || cnt_w[0] !== W'(6) || sv_w !== 1'b1) begin
            errors++;
            $display("FAIL snap_collide snap=%0d cnt=%0d sv=%b required 5 6 1", snp_w[0], cnt_w[0], sv_w);
        end
        step();
        checks++;
        if (sv_w !== 1'b0 || snp_w[0] !== W'(5)) begin
            errors++;
            $display("FAIL snap_pulse sv=%b snap=%0d required 0 5", sv_w, snp_w[0]);
        end
        evt = '0; en = 0;
    endtask

    task automatic test_back_to_back();
        int pre;
        en = 1; evt = 4'b0011; snap = 1;
        for (int i = 0; i < 3; i++) begin
            pre = m_cnt[0][1];
            step();
            checks++;
            if (snp_w[1] !== W'(pre) || sv_w !== 1'b1) begin
                errors++;
                $display("FAIL snap_b2b i=%0d snap=%0d sv=%b required %0d 1", i, snp_w[1], sv_w, pre);
            end
        end
        snap = 0; evt = '0; en = 0;
        step();
    endtask

    task automatic test_disabled();
        int saved[NI][NCH];
        for (int k = 0; k < NI; k++)
            for (int c = 0; c < NCH; c++) saved[k][c] = m_cnt[k][c];
        en = 0;
        for (int i = 0; i < 20; i++) begin
            evt = NCH'($urandom);
            step();
            for (int k = 0; k < NI; k++) begin
                for (int c = 0; c < NCH; c++) begin
                    checks++;
                    if (get_cnt(k, c) !== saved[k][c] || get_tc(k, c) !== 1'b0) begin
                        errors++;
                        $display("FAIL disabled k=%0d c=%0d cnt=%0d tc=%b required %0d 0", k, c, get_cnt(k, c), get_tc(k, c), saved[k][c]);
                    end
                end
            end
        end
        evt = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            evt  = NCH'($urandom);
            clr  = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
            snap = ($urandom_range(0, 3) == 0);
            step();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (get_sv(k) !== m_snapv[k]) begin
                    errors++;
                    $display("FAIL rand_sv cyc=%0d k=%0d got %b required %b", i, k, get_sv(k), m_snapv[k]);
                end
                for (int c = 0; c < NCH; c++) begin
                    checks++;
                    if (get_cnt(k, c) !== m_cnt[k][c] || get_tc(k, c) !== m_tc[k][c] ||
                        get_ovf(k, c) !== m_ovf[k][c] || get_snp(k, c) !== m_snap[k][c]) begin
                        errors++;
                        $display("FAIL rand cyc=%0d k=%0d c=%0d got cnt=%0d tc=%b ovf=%b snap=%0d required cnt=%0d tc=%b ovf=%b snap=%0d",
                                 i, k, c, get_cnt(k, c), get_tc(k, c), get_ovf(k, c), get_snp(k, c),
                                 m_cnt[k][c], m_tc[k][c], m_ovf[k][c], m_snap[k][c]);
                    end
                end
            end
        end
        en = 0; evt = '0; clr = '0; snap = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wrap();
        test_saturate();
        test_edge();
        test_collision();
        test_back_to_back();
        test_disabled();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
